fix_conn_ctrl: RTL

//  Connection sequencer between the application connect/disconnect API and the TOE command FIFO of fix_engine.

---
 rtl/fix_conn_pkg.sv | 7 +
 rtl/fix_conn_ctrl_if.sv | 32 +++
 rtl/fix_rr_arbiter.sv | 32 +++
 rtl/fix_conn_ctrl.sv | 114 +++++++++++
 4 files changed

// File: rtl/fix_conn_pkg.sv
// fix_conn_pkg: shared widths and enums for the fix_engine connection sequencer
package fix_conn_pkg;
  localparam int HOST_W = 2;
  localparam int NUM_HOSTS = 4;
  typedef enum logic [2:0] {IDLE, PEND, WAIT, UP, DPEND} conn_state_t;
  typedef enum logic {CMD_CONNECT, CMD_DISCONNECT} cmd_kind_t;
endpackage

// File: rtl/fix_conn_ctrl_if.sv
// fix_conn_ctrl_if: app/toe/fifo signal bundle of the connection sequencer
interface fix_conn_ctrl_if;
  logic connect_i;
  logic [fix_conn_pkg::HOST_W-1:0] connect_to_host_i;
  logic disconnect_i;
  logic [fix_conn_pkg::HOST_W-1:0] disconnect_host_i;
  logic connected_i;
  logic [fix_conn_pkg::HOST_W-1:0] connected_host_addr_i;
  logic link_down_i;
  logic [fix_conn_pkg::HOST_W-1:0] link_down_host_i;
  logic cmd_ready_i;
  logic connect_req_o;
  logic [fix_conn_pkg::HOST_W-1:0] connect_addr_o;
  logic disconnect_o;
  logic [fix_conn_pkg::HOST_W-1:0] disconnect_host_num_o;
  logic [fix_conn_pkg::NUM_HOSTS-1:0] host_up_o;
  logic conn_fail_o;
  logic [fix_conn_pkg::HOST_W-1:0] conn_fail_host_o;
  logic busy_o;
  modport slave (
    input connect_i, connect_to_host_i, disconnect_i, disconnect_host_i, connected_i,
          connected_host_addr_i, link_down_i, link_down_host_i, cmd_ready_i,
    output connect_req_o, connect_addr_o, disconnect_o, disconnect_host_num_o, host_up_o,
           conn_fail_o, conn_fail_host_o, busy_o
  );
  modport master (
    output connect_i, connect_to_host_i, disconnect_i, disconnect_host_i, connected_i,
           connected_host_addr_i, link_down_i, link_down_host_i, cmd_ready_i,
    input connect_req_o, connect_addr_o, disconnect_o, disconnect_host_num_o, host_up_o,
          conn_fail_o, conn_fail_host_o, busy_o
  );
endinterface

// File: rtl/fix_rr_arbiter.sv
// fix_rr_arbiter: 4-way round-robin grant of the shared command channel
module fix_rr_arbiter
  import fix_conn_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic [NUM_HOSTS-1:0] i_req,
  input  logic i_ready,
  output logic [NUM_HOSTS-1:0] o_gnt,
  output logic [HOST_W-1:0] o_idx
);
  logic [HOST_W-1:0] r_ptr, w_idx;
  logic w_found;
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    w_found = 1'b0;
    w_idx = '0;
    for (int i = 0; i < NUM_HOSTS; i++) begin
      w_idx = r_ptr + HOST_W'(i);
      if (!w_found && i_ready && i_req[w_idx]) begin
        w_found = 1'b1;
        o_gnt[w_idx] = 1'b1;
        o_idx = w_idx;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ptr <= '0;
    else if (w_found) r_ptr <= o_idx + 1'b1;
  end
endmodule

// File: rtl/fix_conn_ctrl.sv
// fix_conn_ctrl: per-host connect/disconnect sequencer sharing one TOE command channel.
// FIX_CONN_AUTORECONNECT_EN: a dropped link re-queues its connect instead of going IDLE.
module fix_conn_ctrl
  import fix_conn_pkg::*;
#(
  parameter int CONN_TIMEOUT = 64,
  parameter int MAX_RETRY = 3
) (
  input logic clk,
  input logic rst,
  fix_conn_ctrl_if.slave bus
);
  localparam int TW = $clog2(CONN_TIMEOUT);
  localparam int RW = $clog2(MAX_RETRY + 1);
  logic [NUM_HOSTS-1:0] w_cn, w_dc, w_ack, w_ld, w_to, w_pend, w_req, w_gnt, w_fail, w_up, w_busy;
  logic [HOST_W-1:0] w_gidx, w_fidx;
  logic w_cgnt, w_dgnt;
  cmd_kind_t w_kind;
  logic r_creq, r_disc, r_fail;
  logic [HOST_W-1:0] r_caddr, r_dhost, r_fhost;
  fix_rr_arbiter u_arb (
    .clk(clk), .rst(rst), .i_req(w_req), .i_ready(bus.cmd_ready_i), .o_gnt(w_gnt), .o_idx(w_gidx)
  );
  for (genvar g = 0; g < NUM_HOSTS; g++) begin : g_host
    conn_state_t r_st;
    logic [TW-1:0] r_tmr;
    logic [RW-1:0] r_rty;
    assign w_cn[g] = bus.connect_i && bus.connect_to_host_i == HOST_W'(g);
    assign w_dc[g] = bus.disconnect_i && bus.disconnect_host_i == HOST_W'(g);
    assign w_ack[g] = bus.connected_i && bus.connected_host_addr_i == HOST_W'(g);
    assign w_ld[g] = bus.link_down_i && bus.link_down_host_i == HOST_W'(g);
    assign w_to[g] = r_st == WAIT && r_tmr == TW'(CONN_TIMEOUT - 1);
    assign w_pend[g] = r_st == PEND;
    assign w_req[g] = w_pend[g] || r_st == DPEND;
    assign w_up[g] = r_st == UP;
    assign w_busy[g] = w_req[g] || r_st == WAIT;
    assign w_fail[g] = w_to[g] && !w_dc[g] && !w_ack[g] && r_rty == RW'(MAX_RETRY);
    // disconnect outranks every other event; a grant in the same cycle still emits its command
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_st <= IDLE;
        r_tmr <= '0;
        r_rty <= '0;
      end else begin
        r_tmr <= r_st == WAIT ? r_tmr + 1'b1 : '0;
        case (r_st)
          IDLE:
            if (w_cn[g] && !w_dc[g]) begin
              r_st <= PEND;
              r_rty <= '0;
            end
          PEND:
            if (w_dc[g]) r_st <= DPEND;
            else if (w_gnt[g]) r_st <= WAIT;
          WAIT:
            if (w_dc[g]) r_st <= DPEND;
            else if (w_ack[g]) begin
              r_st <= UP;
              r_rty <= '0;
            end else if (w_to[g]) begin
              r_st <= w_fail[g] ? IDLE : PEND;
              r_rty <= w_fail[g] ? '0 : r_rty + 1'b1;
            end
          UP:
            if (w_dc[g]) r_st <= DPEND;
            else if (w_ld[g]) begin
`ifdef FIX_CONN_AUTORECONNECT_EN
              r_st <= PEND;
`else
              r_st <= IDLE;
`endif
              r_rty <= '0;
            end
          DPEND:
            if (w_gnt[g]) begin
              r_st <= IDLE;
              r_rty <= '0;
            end
          default: r_st <= IDLE;
        endcase
      end
    end
  end
  assign w_kind = |(w_gnt & w_pend) ? CMD_CONNECT : CMD_DISCONNECT;
  assign w_cgnt = |w_gnt && w_kind == CMD_CONNECT;
  assign w_dgnt = |w_gnt && w_kind == CMD_DISCONNECT;
  // simultaneous failures report only the lowest host
  assign w_fidx = w_fail[0] ? 2'd0 : w_fail[1] ? 2'd1 : w_fail[2] ? 2'd2 : 2'd3;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_creq <= 1'b0;
      r_disc <= 1'b0;
      r_fail <= 1'b0;
      r_caddr <= '0;
      r_dhost <= '0;
      r_fhost <= '0;
    end else begin
      r_creq <= w_cgnt;
      r_disc <= w_dgnt;
      r_fail <= |w_fail;
      if (w_cgnt) r_caddr <= w_gidx;
      if (w_dgnt) r_dhost <= w_gidx;
      if (|w_fail) r_fhost <= w_fidx;
    end
  end
  assign bus.connect_req_o = r_creq;
  assign bus.connect_addr_o = r_caddr;
  assign bus.disconnect_o = r_disc;
  assign bus.disconnect_host_num_o = r_dhost;
  assign bus.conn_fail_o = r_fail;
  assign bus.conn_fail_host_o = r_fhost;
  assign bus.host_up_o = w_up;
  assign bus.busy_o = |w_busy;
endmodule
